// File: rtl/final_soc_usb_irq_pkg.sv
//------------------------------------------------------------------------------
// Module  : final_soc_usb_irq_pkg
// Brief   : Shared constants for the USB OTG interrupt controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package final_soc_usb_irq_pkg;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_CTRL = 2'd1;
   localparam logic [1:0] ADDR_PEND = 2'd2;
   localparam logic [1:0] ADDR_CNT  = 2'd3;

   localparam int CTRL_W      = 3;
   localparam int CTRL_IRQ_EN = 0;
   localparam int CTRL_MODE   = 1;
   localparam int CTRL_POL    = 2;

   localparam int CNT_W = 16;

   typedef enum logic {
      MODE_LEVEL = 1'b0,
      MODE_EDGE  = 1'b1
   } irq_mode_e;

   // pol=0 selects the falling transition, pol=1 the rising one
   function automatic logic edge_active(input logic pol, input logic cur, input logic prev);
      return pol ? (cur & ~prev) : (~cur & prev);
   endfunction

endpackage

`default_nettype wire

// File: rtl/final_soc_usb_irq_filter.sv
//------------------------------------------------------------------------------
// Module  : final_soc_usb_irq_filter
// Brief   : Two-flop synchronizer plus stable-sample glitch filter for INT pin.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module final_soc_usb_irq_filter #(
   parameter int FILTER_CYCLES = 4,
   parameter bit IDLE_LEVEL    = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in_port,
   output logic sync2,
   output logic filt,
   output logic filt_d
);

   localparam logic [7:0] CNT_LAST = 8'(FILTER_CYCLES - 1);

   logic       sync1;
   logic [7:0] stable_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1      <= IDLE_LEVEL;
         sync2      <= IDLE_LEVEL;
         filt       <= IDLE_LEVEL;
         filt_d     <= IDLE_LEVEL;
         stable_cnt <= 8'd0;
      end else begin
         sync1  <= in_port;
         sync2  <= sync1;
         filt_d <= filt;
         // Any sample agreeing with filt restarts the run of mismatches
         if (sync2 == filt) begin
            stable_cnt <= 8'd0;
         end else if (stable_cnt == CNT_LAST) begin
            filt       <= sync2;
            stable_cnt <= 8'd0;
         end else begin
            stable_cnt <= stable_cnt + 8'd1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/final_soc_usb_irq_ctrl.sv
//------------------------------------------------------------------------------
// Module  : final_soc_usb_irq_ctrl
// Brief   : Avalon-MM interrupt controller for the USB OTG INT line.
//           Optional event counter enabled by macro USB_IRQ_EVENT_CNT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module final_soc_usb_irq_ctrl
   import final_soc_usb_irq_pkg::*;
#(
   parameter int FILTER_CYCLES = 4,
   parameter bit IDLE_LEVEL    = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   input  logic        in_port,
   output logic [31:0] readdata,
   output logic        irq
);

   logic              sync2;
   logic              filt;
   logic              filt_d;
   logic              write_en;
   logic              active_edge;
   logic [CTRL_W-1:0] ctrl;
   logic              pending;
   logic [CNT_W-1:0]  event_cnt;
   logic [31:0]       read_mux;
   logic              unused_wdata;

   final_soc_usb_irq_filter #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .IDLE_LEVEL    (IDLE_LEVEL)
   ) u_filter (
      .clk     (clk),
      .reset_n (reset_n),
      .in_port (in_port),
      .sync2   (sync2),
      .filt    (filt),
      .filt_d  (filt_d)
   );

   assign write_en     = chipselect & ~write_n;
   assign active_edge  = edge_active(ctrl[CTRL_POL], filt, filt_d);
   assign unused_wdata = ^writedata[31:CTRL_W];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl <= '0;
      end else if (write_en && address == ADDR_CTRL) begin
         ctrl <= writedata[CTRL_W-1:0];
      end
   end

   // A newly detected edge takes priority over a software clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending <= 1'b0;
      end else if (active_edge) begin
         pending <= 1'b1;
      end else if (write_en && address == ADDR_PEND && writedata[0]) begin
         pending <= 1'b0;
      end
   end

`ifdef USB_IRQ_EVENT_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         event_cnt <= '0;
      end else if (write_en && address == ADDR_CNT) begin
         event_cnt <= active_edge ? CNT_W'(1) : '0;
      end else if (active_edge && event_cnt != '1) begin
         event_cnt <= event_cnt + CNT_W'(1);
      end
   end
`else
   assign event_cnt = '0;
`endif

   always_comb begin
      read_mux = '0;
      case (address)
         ADDR_DATA: read_mux = {30'd0, sync2, filt};
         ADDR_CTRL: read_mux = 32'(ctrl);
         ADDR_PEND: read_mux = {31'd0, pending};
         ADDR_CNT:  read_mux = 32'(event_cnt);
         default:   read_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
         irq      <= 1'b0;
      end else begin
         readdata <= read_mux;
         if (irq_mode_e'(ctrl[CTRL_MODE]) == MODE_EDGE) begin
            irq <= ctrl[CTRL_IRQ_EN] & pending;
         end else begin
            irq <= ctrl[CTRL_IRQ_EN] & (filt == ctrl[CTRL_POL]);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_final_soc_usb_irq_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_final_soc_usb_irq_ctrl
// Brief   : Directed and randomized bench against a cycle-level reference model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_final_soc_usb_irq_ctrl;

   localparam int FC = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic        in_port = 1'b1;
   logic [31:0] readdata;
   logic        irq;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   bit          m_s1, m_s2, m_filt, m_filt_d, m_pend, m_irq;
   bit [2:0]    m_ctrl;
   int          m_cnt;
   logic [31:0] m_rd;
   bit          hist[$];

   final_soc_usb_irq_ctrl #(.FILTER_CYCLES(FC), .IDLE_LEVEL(1'b1)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = 1; m_s2 = 1; m_filt = 1; m_filt_d = 1;
      m_pend = 0; m_irq = 0; m_ctrl = 0; m_cnt = 0; m_rd = 0;
      hist.delete();
   endtask

   // One clock of the model, evaluated from pre-edge state and inputs
   task automatic model_clock();
      bit fo, fdo, pendo, wr, act, all_diff;
      bit [2:0] co;
      fo = m_filt; fdo = m_filt_d; pendo = m_pend; co = m_ctrl;
      wr  = chipselect && !write_n;
      act = co[2] ? (fo && !fdo) : (!fo && fdo);
      case (address)
         2'd0: m_rd = {30'd0, m_s2, m_filt};
         2'd1: m_rd = {29'd0, m_ctrl};
         2'd2: m_rd = {31'd0, m_pend};
         default: m_rd = 32'(m_cnt);
      endcase
      m_irq = co[0] && (co[1] ? pendo : (fo == co[2]));
      if (act) m_pend = 1;
      else if (wr && address == 2'd2 && writedata[0]) m_pend = 0;
      if (wr && address == 2'd1) m_ctrl = writedata[2:0];
`ifdef USB_IRQ_EVENT_CNT_EN
      if (wr && address == 2'd3) m_cnt = act ? 1 : 0;
      else if (act && m_cnt < 65535) m_cnt++;
`endif
      // filt flips once the last FC synchronized samples all disagree with it
      hist.push_back(m_s2);
      if (hist.size() > FC) void'(hist.pop_front());
      all_diff = (hist.size() == FC);
      foreach (hist[i]) if (hist[i] == fo) all_diff = 0;
      m_filt_d = fo;
      if (all_diff) m_filt = !fo;
      m_s2 = m_s1;
      m_s1 = in_port;
   endtask

   task automatic step();
      @(posedge clk);
      if (!reset_n) model_reset();
      else model_clock();
      @(negedge clk);
      check("irq", {31'd0, irq}, {31'd0, m_irq});
      check("readdata", readdata, m_rd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      logic [1:0] keep;
      keep = address;
      chipselect = 1; write_n = 0; address = a; writedata = d;
      step();
      chipselect = 0; write_n = 1; address = keep; writedata = '0;
   endtask

   task automatic pulse_low();
      in_port = 0; idle(10);
      in_port = 1; idle(10);
   endtask

   initial begin
      model_reset();
      idle(3);
      check("reset_rd", readdata, 32'h0);
      check("reset_irq", {31'd0, irq}, 32'h0);
      reset_n = 1;
      idle(3);

      // Edge mode, falling, enabled: pending at edge 7, irq at edge 8
      bus_write(2'd1, 32'h3);
      address = 2'd2;
      in_port = 0;
      for (int k = 1; k <= 8; k++) begin
         step();
         if (k == 7) check("t1_irq_e7", {31'd0, irq}, 32'h0);
         if (k == 8) begin
            check("t1_irq_e8", {31'd0, irq}, 32'h1);
            check("t1_pend_rd", readdata, 32'h1);
         end
      end
      in_port = 1; idle(10);
      bus_write(2'd2, 32'h1);
      idle(2);
      check("t1_cleared", readdata, 32'h0);

      // Three-cycle glitch is filtered out
      in_port = 0; idle(3);
      in_port = 1; idle(12);
      check("t2_pend", readdata, 32'h0);
      check("t2_irq", {31'd0, irq}, 32'h0);

      // Clear coinciding with edge detection: set wins
      pulse_low();
      in_port = 0; idle(6);
      bus_write(2'd2, 32'h1);
      idle(2);
      check("t3_set_wins", readdata, 32'h1);
      bus_write(2'd2, 32'h1);
      idle(1);
      check("t3_clr_rd", readdata, 32'h0);
      check("t3_clr_irq", {31'd0, irq}, 32'h0);

      // Level mode, active low
      bus_write(2'd1, 32'h1);
      idle(3);
      check("t4_level_hi", {31'd0, irq}, 32'h1);
      in_port = 1; idle(12);
      check("t4_level_lo", {31'd0, irq}, 32'h0);
      pulse_low();
      check("t4_pend_track", readdata, 32'h1);

      // Reset in mid-filter, release with pin high
      in_port = 0; idle(4);
      reset_n = 0; in_port = 1;
      idle(2);
      reset_n = 1;
      idle(1);
      check("t5_rd", readdata, 32'h0);
      check("t5_irq", {31'd0, irq}, 32'h0);
      address = 2'd0;
      idle(1);
      check("t5_filt", readdata, 32'h3);
      address = 2'd2;
      idle(10);
      check("t5_nopend", readdata, 32'h0);

`ifdef USB_IRQ_EVENT_CNT_EN
      bus_write(2'd1, 32'h3);
      bus_write(2'd3, 32'h0);
      for (int p = 0; p < 3; p++) pulse_low();
      address = 2'd3;
      idle(2);
      check("t6_cnt3", readdata, 32'h3);
      bus_write(2'd3, 32'h0);
      idle(2);
      check("t6_cnt_clr", readdata, 32'h0);
`else
      address = 2'd3;
      pulse_low();
      check("t6_cnt_off", readdata, 32'h0);
`endif

      // Randomized pin runs and bus traffic
      for (int it = 0; it < 300; it++) begin
         in_port = 1'($urandom_range(0, 1));
         for (int c = $urandom_range(1, 8); c > 0; c--) begin
            address = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n = ($urandom_range(0, 9) < 2) ? 1'b0 : 1'b1;
            writedata = $urandom;
            step();
         end
      end
      chipselect = 0; write_n = 1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
